// File: rtl/request_output_mux_if.sv
// request_output_mux_if: request channel and transport pipe handshake bundle.
interface request_output_mux_if #(
  parameter int NUM_CH     = 4,
  parameter int ARG_WIDTH  = 64,
  parameter int BEAT_WIDTH = 32
);
  logic [NUM_CH-1:0]           request_ena;
  logic [NUM_CH-1:0]           request_rdy;
  logic [NUM_CH*ARG_WIDTH-1:0] request_v;
  logic                        enq_ena;
  logic                        enq_last;
  logic                        enq_rdy;
  logic [BEAT_WIDTH-1:0]       enq_v;
  modport master (output request_ena, request_v, enq_rdy,
                  input  request_rdy, enq_ena, enq_v, enq_last);
  modport slave  (input  request_ena, request_v, enq_rdy,
                  output request_rdy, enq_ena, enq_v, enq_last);
endinterface

// File: rtl/request_output_mux.sv
// request_output_mux: round-robin request arbiter, message FIFO and beat serialiser onto the pipe.
module request_output_mux #(
  parameter  int NUM_CH     = 4,
  parameter  int ARG_WIDTH  = 64,
  parameter  int ID_WIDTH   = 32,
  parameter  int BEAT_WIDTH = 32,
  parameter  int DEPTH      = 4,
  localparam int CW         = $clog2(DEPTH) + 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  request_output_mux_if.slave    bus,
  output logic [CW-1:0]          count
);
  localparam int MSG_WIDTH = ARG_WIDTH + ID_WIDTH;
  localparam int BEATS     = (MSG_WIDTH + BEAT_WIDTH - 1) / BEAT_WIDTH;
  localparam int PW        = BEATS * BEAT_WIDTH;
  localparam int AW        = $clog2(DEPTH);
  localparam int BW        = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int CHW       = NUM_CH > 1 ? $clog2(NUM_CH) : 1;

  logic [PW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wp, rp;
  logic [BW-1:0]     beat;
  logic [CHW-1:0]    rr, g;
  logic [NUM_CH-1:0] grant;
  logic [PW-1:0]     msg;
  logic              full, push, pop, last;

  always_comb begin
    grant = '0;
    g     = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (grant == '0 && bus.request_ena[(int'(rr) + k) % NUM_CH]) begin
        grant[(int'(rr) + k) % NUM_CH] = 1'b1;
        g = CHW'((int'(rr) + k) % NUM_CH);
      end
  end

  // full looks at registered occupancy only, so a same-cycle pop never frees a slot
  assign full            = count == CW'(DEPTH);
  assign bus.request_rdy = (full || RST) ? '0 : grant;
  assign push            = |(bus.request_ena & bus.request_rdy);
  assign msg             = PW'({bus.request_v[int'(g)*ARG_WIDTH +: ARG_WIDTH], ID_WIDTH'(g) + ID_WIDTH'(1)});

  assign last         = beat == BW'(BEATS - 1);
  assign bus.enq_ena  = count != '0;
  assign bus.enq_last = bus.enq_ena && last;
  assign bus.enq_v    = bus.enq_ena ? mem[rp][int'(beat)*BEAT_WIDTH +: BEAT_WIDTH] : '0;
  assign pop          = bus.enq_ena && bus.enq_rdy && last;

  always_ff @(posedge CLK)
    if (push) mem[wp] <= msg;

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      wp    <= '0;
      rp    <= '0;
      rr    <= '0;
      beat  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wp <= wp + 1'b1;
        rr <= (int'(g) == NUM_CH - 1) ? '0 : g + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      if (bus.enq_ena && bus.enq_rdy) beat <= last ? '0 : beat + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: tb/tb_request_output_mux.sv
// tb_request_output_mux: scoreboard bench for the round-robin request output mux.
module tb_request_output_mux;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } beat_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  ena = 4'b0;
  logic        pipe_rdy = 1'b0;
  logic [63:0] args [4];
  logic [2:0]  count;
  int          errors = 0;
  int          checks = 0;
  int          m_cnt = 0;
  int          m_rr = 0;
  beat_t       sb[$];

  request_output_mux_if #(.NUM_CH(4), .ARG_WIDTH(64), .BEAT_WIDTH(32)) bus();
  assign bus.request_ena = ena;
  assign bus.enq_rdy     = pipe_rdy;
  assign bus.request_v   = {args[3], args[2], args[1], args[0]};

  request_output_mux dut (.CLK(CLK), .RST(RST), .bus(bus.slave), .count(count));

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: predicts grants, occupancy and every beat the pipe should see
  always @(negedge CLK or posedge RST) begin : mon
    int          gi;
    logic [3:0]  er;
    logic [95:0] msg;
    beat_t       b;
    if (RST) begin
      sb.delete();
      m_cnt = 0;
      m_rr  = 0;
    end else begin
      gi = -1;
      for (int k = 0; k < 4; k++)
        if (gi < 0 && ena[(m_rr + k) % 4]) gi = (m_rr + k) % 4;
      er = (gi >= 0 && m_cnt < DEPTH) ? 4'(1 << gi) : 4'b0;
      checks++;
      if (bus.request_rdy !== er) begin
        errors++;
        $display("FAIL rdy: got %b want %b", bus.request_rdy, er);
      end
      checks++;
      if (count !== 3'(m_cnt)) begin
        errors++;
        $display("FAIL count: got %0d want %0d", count, m_cnt);
      end
      checks++;
      if (bus.enq_ena !== (m_cnt != 0)) begin
        errors++;
        $display("FAIL enq_ena: got %b want %b", bus.enq_ena, m_cnt != 0);
      end
      if (m_cnt != 0) begin
        b = sb[0];
        checks++;
        if (bus.enq_v !== b.d || bus.enq_last !== b.l) begin
          errors++;
          $display("FAIL beat: got %h/%b want %h/%b", bus.enq_v, bus.enq_last, b.d, b.l);
        end
        if (pipe_rdy) begin
          void'(sb.pop_front());
          if (b.l) m_cnt--;
        end
      end
      if (er != 0) begin
        msg = {args[gi], 32'(gi + 1)};
        for (int k = 0; k < 3; k++) begin
          b.d = msg[k*32 +: 32];
          b.l = (k == 2);
          sb.push_back(b);
        end
        m_cnt++;
        m_rr = (gi + 1) % 4;
      end
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_reset;
    tick();
    RST = 1'b1;
    #1 RST = 1'b0;
  endtask

  task automatic wait_idle;
    pipe_rdy = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(negedge CLK);
      if (!bus.enq_ena) break;
    end
    checks++;
    if (bus.enq_ena !== 1'b0) begin
      errors++;
      $display("FAIL drain: enq_ena got %b want 0", bus.enq_ena);
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 4; i++) args[i] = 64'h0;
    RST = 1'b1;
    ena = 4'b1111;
    pipe_rdy = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if (bus.request_rdy !== 4'b0) begin
      errors++;
      $display("FAIL reset_rdy: got %b want 0000", bus.request_rdy);
    end
    checks++;
    if ({bus.enq_ena, bus.enq_last, bus.enq_v} !== 34'h0 || count !== 3'd0) begin
      errors++;
      $display("FAIL reset_out: got ena=%b last=%b v=%h count=%0d want all 0", bus.enq_ena, bus.enq_last, bus.enq_v, count);
    end
    tick();
    RST = 1'b0;
    ena = 4'b0001;
    pipe_rdy = 1'b0;
    tick();
    ena = 4'b0;
    checks++;
    if (count !== 3'd1) begin
      errors++;
      $display("FAIL pre_async_count: got %0d want 1", count);
    end
    #2 RST = 1'b1;
    #1;
    checks++;
    if (count !== 3'd0 || bus.enq_ena !== 1'b0 || bus.enq_v !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: got count=%0d ena=%b v=%h want 0", count, bus.enq_ena, bus.enq_v);
    end
    #1 RST = 1'b0;
  endtask

  task automatic test_single;
    pulse_reset();
    pipe_rdy = 1'b1;
    args[1] = 64'h1111_2222_3333_4444;
    ena = 4'b0010;
    @(negedge CLK);
    checks++;
    if (bus.request_rdy !== 4'b0010) begin
      errors++;
      $display("FAIL single_rdy: got %b want 0010", bus.request_rdy);
    end
    tick();
    ena = 4'b0;
    @(negedge CLK);
    checks++;
    if (bus.enq_ena !== 1'b1 || bus.enq_v !== 32'd2 || bus.enq_last !== 1'b0) begin
      errors++;
      $display("FAIL single_b0: got %b/%h/%b want 1/00000002/0", bus.enq_ena, bus.enq_v, bus.enq_last);
    end
    @(negedge CLK);
    checks++;
    if (bus.enq_v !== 32'h3333_4444 || bus.enq_last !== 1'b0) begin
      errors++;
      $display("FAIL single_b1: got %h/%b want 33334444/0", bus.enq_v, bus.enq_last);
    end
    @(negedge CLK);
    checks++;
    if (bus.enq_v !== 32'h1111_2222 || bus.enq_last !== 1'b1) begin
      errors++;
      $display("FAIL single_b2: got %h/%b want 11112222/1", bus.enq_v, bus.enq_last);
    end
    @(negedge CLK);
    checks++;
    if (bus.enq_ena !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: enq_ena got %b want 0", bus.enq_ena);
    end
  endtask

  task automatic test_round_robin;
    int n = 0;
    pulse_reset();
    for (int i = 0; i < 4; i++) args[i] = {32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i)};
    pipe_rdy = 1'b1;
    ena = 4'b1111;
    for (int c = 0; c < 60 && n < 5; c++) begin
      @(negedge CLK);
      if (bus.request_rdy != 4'b0) begin
        checks++;
        if (bus.request_rdy !== 4'(1 << (n % 4))) begin
          errors++;
          $display("FAIL rr_grant%0d: got %b want %b", n, bus.request_rdy, 4'(1 << (n % 4)));
        end
        n++;
      end
    end
    tick();
    ena = 4'b0;
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL rr_timeout: got %0d grants want 5", n);
    end
    wait_idle();
  endtask

  task automatic test_full;
    pulse_reset();
    args[0] = 64'hDEAD_BEEF_0BAD_F00D;
    pipe_rdy = 1'b0;
    ena = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checks++;
      if (bus.request_rdy !== 4'b0001) begin
        errors++;
        $display("FAIL fill%0d: rdy got %b want 0001", i, bus.request_rdy);
      end
    end
    @(negedge CLK);
    checks++;
    if (bus.request_rdy !== 4'b0 || count !== 3'd4) begin
      errors++;
      $display("FAIL full: got rdy=%b count=%0d want 0000/4", bus.request_rdy, count);
    end
    tick();
    pipe_rdy = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if (bus.enq_last !== 1'b1 || bus.request_rdy !== 4'b0) begin
      errors++;
      $display("FAIL no_passthru: got last=%b rdy=%b want 1/0000", bus.enq_last, bus.request_rdy);
    end
    @(negedge CLK);
    checks++;
    if (bus.request_rdy !== 4'b0001 || count !== 3'd3) begin
      errors++;
      $display("FAIL refill: got rdy=%b count=%0d want 0001/3", bus.request_rdy, count);
    end
    tick();
    ena = 4'b0;
    wait_idle();
  endtask

  task automatic test_push_pop;
    pulse_reset();
    args[0] = 64'h0123_4567_89AB_CDEF;
    args[2] = 64'hFEDC_BA98_7654_3210;
    pipe_rdy = 1'b0;
    ena = 4'b0001;
    repeat (2) tick();
    ena = 4'b0;
    checks++;
    if (count !== 3'd2) begin
      errors++;
      $display("FAIL pp_fill: count got %0d want 2", count);
    end
    tick();
    pipe_rdy = 1'b1;
    repeat (2) tick();
    ena = 4'b0100;
    @(negedge CLK);
    checks++;
    if (bus.enq_last !== 1'b1 || bus.request_rdy !== 4'b0100 || count !== 3'd2) begin
      errors++;
      $display("FAIL pp_setup: got last=%b rdy=%b count=%0d want 1/0100/2", bus.enq_last, bus.request_rdy, count);
    end
    tick();
    ena = 4'b0;
    checks++;
    if (count !== 3'd2) begin
      errors++;
      $display("FAIL pp_count: got %0d want 2", count);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid;
    pulse_reset();
    args[0] = 64'hAAAA_BBBB_CCCC_DDDD;
    args[1] = 64'h5555_6666_7777_8888;
    pipe_rdy = 1'b1;
    ena = 4'b0001;
    tick();
    ena = 4'b0;
    repeat (2) tick();
    RST = 1'b1;
    #1;
    checks++;
    if (bus.enq_ena !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL mid_reset: got ena=%b count=%0d want 0/0", bus.enq_ena, count);
    end
    #1 RST = 1'b0;
    ena = 4'b0010;
    tick();
    ena = 4'b0;
    @(negedge CLK);
    checks++;
    if (bus.enq_v !== 32'd2 || bus.enq_last !== 1'b0) begin
      errors++;
      $display("FAIL mid_header: got %h/%b want 00000002/0", bus.enq_v, bus.enq_last);
    end
    wait_idle();
  endtask

  task automatic test_random_stall;
    pulse_reset();
    for (int i = 0; i < 4; i++) args[i] = {$urandom, $urandom};
    for (int c = 0; c < 60; c++) begin
      tick();
      ena = 4'($urandom);
      pipe_rdy = 1'($urandom);
    end
    tick();
    ena = 4'b0;
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_push_pop();
    test_reset_mid();
    test_random_stall();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d beats want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
